// File: rtl/port_rd_ctrl.sv
// port_rd_ctrl: per-queue packet accounting plus a single-outstanding read
// controller that fetches the queue the dispatcher points at. After each read
// completes, the controller signals the dispatcher and then waits a fixed
// settle time before it samples prior_next again.
//
// Optional feature: define PORT_RD_CTRL_STAT_EN to build the 32-bit
// completed-read counter on rd_pkt_cnt. When the macro is undefined,
// rd_pkt_cnt is tied to 0 and no counter register exists.

module port_rd_ctrl #(
    parameter int QUEUE_CNT_W   = 8,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enq_valid,
    input  logic [2:0]  enq_queue,
    output logic        enq_overflow,
    output logic [7:0]  queue_empty,
    input  logic [3:0]  prior_next,
    output logic        prior_update,
    output logic        rd_req,
    output logic [2:0]  rd_queue,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        busy,
    output logic [31:0] rd_pkt_cnt
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [QUEUE_CNT_W-1:0] CNT_MAX     = {QUEUE_CNT_W{1'b1}};
    localparam logic [QUEUE_CNT_W-1:0] CNT_ONE     = QUEUE_CNT_W'(1'b1);
    localparam logic [SETTLE_W-1:0]    SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]    SETTLE_ONE  = SETTLE_W'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [QUEUE_CNT_W-1:0] cnt_r      [8];
    logic [QUEUE_CNT_W-1:0] cnt_next_s [8];
    logic [7:0]             enq_hit_s;
    logic [7:0]             deq_hit_s;
    logic                   ovf_next_s;
    logic                   rd_fire_s;
    logic                   start_s;
    logic [SETTLE_W-1:0]    settle_cnt_r;

    logic                   rd_req_r;
    logic [2:0]             rd_queue_r;
    logic                   prior_update_r;
    logic                   busy_r;
    logic                   enq_overflow_r;
    logic                   rd_req_next_s;
    logic [2:0]             rd_queue_next_s;
    logic                   prior_update_next_s;
    logic                   busy_next_s;

    // A packet leaves its queue when the memory accepts the read request.
    assign rd_fire_s = rd_req_r & rd_ack;

    // Decode which queue is being enqueued and which is being dequeued.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            enq_hit_s[i] = enq_valid && (enq_queue == 3'(i));
            deq_hit_s[i] = rd_fire_s && (rd_queue_r == 3'(i));
        end
    end

    // Next counter values: saturating increment, guarded decrement, and a
    // simultaneous enqueue/dequeue on the same queue cancels out.
    always_comb begin
        ovf_next_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cnt_next_s[i] = cnt_r[i];
            case ({enq_hit_s[i], deq_hit_s[i]})
                2'b10: begin
                    if (cnt_r[i] == CNT_MAX) begin
                        ovf_next_s = 1'b1;
                    end else begin
                        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_r[i] != '0) begin
                        cnt_next_s[i] = cnt_r[i] - CNT_ONE;
                    end else begin
                        cnt_next_s[i] = cnt_r[i];
                    end
                end
                default: cnt_next_s[i] = cnt_r[i];
            endcase
        end
    end

    // Per-queue packet counters and the overflow pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt_r[i] <= '0;
            end
            enq_overflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            enq_overflow_r <= ovf_next_s;
        end
    end

    // Empty flags go straight from the counters so the dispatcher sees them
    // in the same cycle the count changes.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            queue_empty[i] = (cnt_r[i] == '0);
        end
    end

    // A read can start only when the dispatcher names a real, non-empty queue.
    assign start_s = (prior_next < 4'd8) && !queue_empty[prior_next[2:0]];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; rd_done is only looked at while waiting for data.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_next_s = S_ISSUE;
                else         state_next_s = S_IDLE;
            end
            S_ISSUE: begin
                if (rd_ack) state_next_s = S_WAIT;
                else        state_next_s = S_ISSUE;
            end
            S_WAIT: begin
                if (rd_done) state_next_s = S_UPDATE;
                else         state_next_s = S_WAIT;
            end
            S_UPDATE: state_next_s = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt_r == '0) state_next_s = S_IDLE;
                else                    state_next_s = S_SETTLE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM output logic: outputs are decoded from the next state so that the
    // registered versions line up exactly with the state they describe.
    always_comb begin
        rd_req_next_s       = (state_next_s == S_ISSUE);
        prior_update_next_s = (state_next_s == S_UPDATE);
        busy_next_s         = (state_next_s != S_IDLE);
        if ((state_r == S_IDLE) && start_s) begin
            rd_queue_next_s = prior_next[2:0];
        end else begin
            rd_queue_next_s = rd_queue_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_r       <= 1'b0;
            rd_queue_r     <= 3'd0;
            prior_update_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            rd_req_r       <= rd_req_next_s;
            rd_queue_r     <= rd_queue_next_s;
            prior_update_r <= prior_update_next_s;
            busy_r         <= busy_next_s;
        end
    end

    // Settle timer: loaded on the update cycle, counts down while settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= '0;
        end else if (state_r == S_UPDATE) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == S_SETTLE) && (settle_cnt_r != '0)) begin
            settle_cnt_r <= settle_cnt_r - SETTLE_ONE;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

`ifdef PORT_RD_CTRL_STAT_EN
    logic [31:0] pkt_cnt_r;

    // Completed-read counter, bumped once per update cycle; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r <= 32'd0;
        end else if (state_r == S_UPDATE) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign rd_pkt_cnt = pkt_cnt_r;
`else
    assign rd_pkt_cnt = 32'd0;
`endif

    assign rd_req       = rd_req_r;
    assign rd_queue     = rd_queue_r;
    assign prior_update = prior_update_r;
    assign busy         = busy_r;
    assign enq_overflow = enq_overflow_r;

endmodule

// File: tb/tb_port_rd_ctrl.sv
// Testbench for port_rd_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
`timescale 1ns/1ps

module tb_port_rd_ctrl;

    localparam int CW   = 3;
    localparam int SC   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enq_valid = 1'b0;
    logic [2:0]  enq_queue = 3'd0;
    logic        enq_overflow;
    logic [7:0]  queue_empty;
    logic [3:0]  prior_next = 4'd8;
    logic        prior_update;
    logic        rd_req;
    logic [2:0]  rd_queue;
    logic        rd_ack = 1'b0;
    logic        rd_done = 1'b0;
    logic        busy;
    logic [31:0] rd_pkt_cnt;

    port_rd_ctrl #(.QUEUE_CNT_W(CW), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_queue(enq_queue), .enq_overflow(enq_overflow),
        .queue_empty(queue_empty), .prior_next(prior_next), .prior_update(prior_update),
        .rd_req(rd_req), .rd_queue(rd_queue), .rd_ack(rd_ack), .rd_done(rd_done),
        .busy(busy), .rd_pkt_cnt(rd_pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: packet counts per queue, and the read as a timeline
    // (requesting, waiting for data, then non-idle until a computed cycle).
    int          m_cnt [8];
    bit          m_req, m_wait, m_upd, m_ovf, m_busy;
    int          m_q;
    int          m_idle_at;
    int          k;
    logic [31:0] m_pkt;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    endtask

    function automatic void model_reset();
        for (int q = 0; q < 8; q++) m_cnt[q] = 0;
        m_req = 1'b0; m_wait = 1'b0; m_upd = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
        m_q = 0; m_idle_at = 0; m_pkt = 32'd0;
    endfunction

    function automatic void model_step();
        bit start, fire, enq_h, deq_h, was_upd;
        int pn;
        k++;
        was_upd = m_upd;
        m_upd   = 1'b0;
        m_ovf   = 1'b0;
        pn      = int'(prior_next);
        start   = 1'b0;
        if (!m_busy && pn < 8) start = (m_cnt[pn] != 0);
        fire = m_req && rd_ack;
        for (int q = 0; q < 8; q++) begin
            enq_h = enq_valid && (int'(enq_queue) == q);
            deq_h = fire && (m_q == q);
            if (enq_h && !deq_h) begin
                if (m_cnt[q] == CMAX) m_ovf = 1'b1;
                else m_cnt[q]++;
            end else if (deq_h && !enq_h) begin
                m_cnt[q]--;
            end
        end
        if (m_req) begin
            if (rd_ack) begin m_req = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
            if (rd_done) begin
                m_wait = 1'b0; m_upd = 1'b1; m_idle_at = k + SC + 1;
            end
        end else if (start) begin
            m_req = 1'b1; m_q = pn;
        end
`ifdef PORT_RD_CTRL_STAT_EN
        if (was_upd) m_pkt = m_pkt + 32'd1;
`endif
        m_busy = m_req || m_wait || (k < m_idle_at);
    endfunction

    task automatic check_outputs();
        logic [7:0] e;
        for (int q = 0; q < 8; q++) e[q] = (m_cnt[q] == 0);
        check_val("rd_req",       32'(rd_req),       32'(m_req));
        check_val("rd_queue",     32'(rd_queue),     32'(m_q));
        check_val("prior_update", 32'(prior_update), 32'(m_upd));
        check_val("busy",         32'(busy),         32'(m_busy));
        check_val("enq_overflow", 32'(enq_overflow), 32'(m_ovf));
        check_val("queue_empty",  32'(queue_empty),  32'(e));
        check_val("rd_pkt_cnt",   rd_pkt_cnt,        m_pkt);
    endtask

    task automatic quiet();
        enq_valid = 1'b0; enq_queue = 3'd0; prior_next = 4'd8; rd_ack = 1'b0; rd_done = 1'b0;
    endtask

    // Inputs are applied at the falling edge; outputs are checked at the next one.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset mid-cycle with junk on the inputs; called at a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_val("rst_empty", 32'(queue_empty), 32'hFF);
        enq_valid = 1'b1; enq_queue = 3'($urandom_range(0, 7));
        prior_next = 4'($urandom_range(0, 7)); rd_ack = 1'b1; rd_done = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        quiet();
        rst_n = 1'b1;
    endtask

    task automatic enqueue(input int q);
        enq_valid = 1'b1; enq_queue = 3'(q);
        step();
        enq_valid = 1'b0;
    endtask

    // Serve one read of queue pn: ack while requested, rd_done dly cycles after.
    task automatic serve_read(input int pn, input int dly);
        int cd, upd;
        cd = -1; upd = 0;
        prior_next = 4'(pn);
        for (int c = 0; c < 30; c++) begin
            rd_ack  = rd_req;
            rd_done = (cd == 0);
            if (rd_ack) cd = dly;
            else if (cd >= 0) cd--;
            if (rd_req) prior_next = 4'd8;
            step();
            upd += int'(prior_update);
        end
        quiet();
        check_val("upd_pulses", 32'(upd), 32'd1);
    endtask

    initial begin
        int ovf_seen, n;
        k = 0;
        model_reset();
        quiet();
        repeat (2) @(negedge clk);
        check_outputs();
        check_val("rst_empty", 32'(queue_empty), 32'hFF);
        rst_n = 1'b1;

        // Three packets into queue 2 with no dispatcher choice.
        prior_next = 4'd8;
        repeat (3) enqueue(2);
        step(); step();
        check_val("empty_fb", 32'(queue_empty), 32'hFB);
        check_val("idle_no_req", 32'(rd_req), 32'd0);

        // Full read of queue 2 with rd_done several cycles after the ack.
        serve_read(2, 3);

        // Enqueue and dequeue on queue 1 in the same cycle.
        do_reset();
        enqueue(1);
        prior_next = 4'd1;
        step();
        check_val("req_q1", 32'(rd_req), 32'd1);
        prior_next = 4'd8; rd_ack = 1'b1; enq_valid = 1'b1; enq_queue = 3'd1;
        step();
        check_val("same_q_empty1", 32'(queue_empty[1]), 32'd0);
        check_val("same_q_ovf", 32'(enq_overflow), 32'd0);
        quiet();
        rd_done = 1'b1; step(); rd_done = 1'b0;
        repeat (SC + 3) step();

        // Saturation of queue 0, then drain it completely.
        do_reset();
        ovf_seen = 0;
        for (int i = 0; i <= CMAX; i++) begin
            enqueue(0);
            ovf_seen += int'(enq_overflow);
        end
        step();
        ovf_seen += int'(enq_overflow);
        check_val("ovf_pulses", 32'(ovf_seen), 32'd1);
        for (int i = 0; i < CMAX; i++) begin
            if (i == CMAX - 1) check_val("q0_not_empty", 32'(queue_empty[0]), 32'd0);
            serve_read(0, 1);
        end
        check_val("q0_drained", 32'(queue_empty[0]), 32'd1);

        // Reset while waiting for data, rd_done showing up during reset.
        do_reset();
        enqueue(4);
        prior_next = 4'd4;
        n = 0;
        while (!rd_req && n < 10) begin step(); n++; end
        check_val("req_rise", 32'(rd_req), 32'd1);
        prior_next = 4'd8; rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check_val("in_wait_busy", 32'(busy), 32'd1);
        do_reset();
        repeat (4) step();
        check_val("abandon_upd", 32'(prior_update), 32'd0);
        check_val("abandon_empty", 32'(queue_empty), 32'hFF);

        // Ten completed reads for the statistics counter.
        do_reset();
        for (int i = 0; i < 10; i++) enqueue(i % 8);
        for (int i = 0; i < 10; i++) serve_read(i % 8, 1);
`ifdef PORT_RD_CTRL_STAT_EN
        check_val("pkt_cnt_10", rd_pkt_cnt, 32'd10);
`else
        check_val("pkt_cnt_0", rd_pkt_cnt, 32'd0);
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                enq_valid  = ($urandom_range(0, 99) < 40);
                enq_queue  = 3'($urandom_range(0, 7));
                prior_next = 4'($urandom_range(0, 9));
                rd_ack     = rd_req ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
                rd_done    = ($urandom_range(0, 99) < 30);
                step();
            end
        end
        quiet();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
